// File: rtl/turn_input_conditioner.sv
// Lever-switch conditioner for the turn-signal FSM: synchronises, debounces and
// resolves left/right conflicts, updating its outputs only on the slow tick.
module turn_input_conditioner #(
    parameter int DB_COUNT = 16,
    parameter int TICK_DIV = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic left_sw,
    input  logic right_sw,
    output logic left,
    output logic right,
    output logic hazard,
    output logic tick
);

    localparam int CW = $clog2(DB_COUNT);
    localparam int TW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_COUNT - 1);
    localparam logic [TW-1:0] TC_LAST  = TW'(TICK_DIV - 1);

    logic [1:0]    sw;
    logic [1:0]    db;
    logic [TW-1:0] tc;

    assign sw = {right_sw, left_sw};

    // Channel 0 is left, channel 1 is right.
    for (genvar g = 0; g < 2; g++) begin : g_ch
        logic          s1;
        logic          s2;
        logic          db_r;
        logic [CW-1:0] cnt;

        always_ff @(posedge clk) begin
            if (reset) begin
                s1   <= 1'b0;
                s2   <= 1'b0;
                db_r <= 1'b0;
                cnt  <= '0;
            end else begin
                s1 <= sw[g];
                s2 <= s1;
                if (s2 == db_r) begin
                    cnt <= '0;
                end else if (cnt == CNT_LAST) begin
                    db_r <= s2;
                    cnt  <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end

        assign db[g] = db_r;
    end

    // Outputs sample the debounced levels only on the tick-wrap edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            tc     <= '0;
            tick   <= 1'b0;
            left   <= 1'b0;
            right  <= 1'b0;
            hazard <= 1'b0;
        end else if (tc == TC_LAST) begin
            tc     <= '0;
            tick   <= 1'b1;
            left   <= db[0] & ~db[1];
            right  <= db[1] & ~db[0];
            hazard <= db[0] & db[1];
        end else begin
            tc   <= tc + 1'b1;
            tick <= 1'b0;
        end
    end

endmodule

// File: tb/tb_turn_input_conditioner.sv
// Directed bench for turn_input_conditioner with DB_COUNT=4, TICK_DIV=8.
// Observed vector order is {left, right, hazard, tick}.
module tb_turn_input_conditioner;

    logic clk = 1'b0;
    logic reset;
    logic left_sw;
    logic right_sw;
    logic left;
    logic right;
    logic hazard;
    logic tick;

    int tests = 0;
    int fails = 0;

    turn_input_conditioner #(
        .DB_COUNT(4),
        .TICK_DIV(8)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .left_sw (left_sw),
        .right_sw(right_sw),
        .left    (left),
        .right   (right),
        .hazard  (hazard),
        .tick    (tick)
    );

    always #5 clk = ~clk;

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [3:0] exp);
        tests++;
        assert ({left, right, hazard, tick} === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, {left, right, hazard, tick}, exp);
        end
    endtask

    task automatic check_span(input string tag, input int n, input logic [3:0] exp);
        for (int i = 0; i < n; i++) begin
            cycles(1);
            chk(tag, exp);
        end
    endtask

    // From just after a tick edge: 7 quiet edges holding lrh, then the tick edge.
    task automatic period(input string tag, input logic [2:0] hold, input logic [2:0] upd);
        check_span(tag, 7, {hold, 1'b0});
        cycles(1);
        chk(tag, {upd, 1'b1});
    endtask

    initial begin
        // Reset with random switch levels
        reset    = 1'b1;
        left_sw  = 1'($urandom);
        right_sw = 1'($urandom);
        cycles(3);
        chk("reset", 4'b0000);
        reset    = 1'b0;
        left_sw  = 1'b0;
        right_sw = 1'b0;
        period("tick_first", 3'b000, 3'b000);
        period("tick_second", 3'b000, 3'b000);

        // Clean press: db rises at edge 6, seen at edge 8
        left_sw = 1'b1;
        period("press", 3'b000, 3'b100);
        left_sw = 1'b0;
        period("release", 3'b100, 3'b000);

        // Press set after edge 2: db rises on edge 8 itself, so missed until edge 16
        cycles(2);
        left_sw = 1'b1;
        check_span("late_press", 5, 4'b0000);
        cycles(1);
        chk("late_press_tick", 4'b0001);
        period("late_press_seen", 3'b000, 3'b100);
        // Release after edge 1: db falls on edge 7, just in time for edge 8
        cycles(1);
        left_sw = 1'b0;
        check_span("early_rel", 6, 4'b1000);
        cycles(1);
        chk("early_rel_tick", 4'b0001);

        // Glitch: right high 3 cycles is one short of acceptance
        right_sw = 1'b1;
        cycles(3);
        right_sw = 1'b0;
        cycles(5);
        chk("glitch_tick1", 4'b0001);
        // Bounce 1-0-1-0 with 2-cycle pulses
        right_sw = 1'b1;
        cycles(2);
        right_sw = 1'b0;
        cycles(2);
        right_sw = 1'b1;
        cycles(2);
        right_sw = 1'b0;
        cycles(2);
        chk("glitch_tick2", 4'b0001);
        period("glitch_p3", 3'b000, 3'b000);
        period("glitch_p4", 3'b000, 3'b000);

        // Conflict resolution
        left_sw = 1'b1;
        period("conf_left", 3'b000, 3'b100);
        right_sw = 1'b1;
        period("conf_both", 3'b100, 3'b001);
        left_sw = 1'b0;
        period("conf_right", 3'b001, 3'b010);
        right_sw = 1'b0;
        period("conf_idle", 3'b010, 3'b000);

        // Reset when the left debounce counter has reached 2
        left_sw = 1'b1;
        cycles(4);
        reset = 1'b1;
        cycles(1);
        chk("rst_mid_press", 4'b0000);
        reset = 1'b0;
        period("rst_repress", 3'b000, 3'b100);

        // Reset while left=1; a later press needs the full debounce again
        cycles(3);
        reset   = 1'b1;
        left_sw = 1'b0;
        cycles(2);
        chk("rst_left_on", 4'b0000);
        reset = 1'b0;
        cycles(2);
        left_sw = 1'b1;
        check_span("rst_phase", 5, 4'b0000);
        cycles(1);
        chk("rst_phase_tick", 4'b0001);
        period("rst_press_seen", 3'b000, 3'b100);

        // Tick-hold: db falls one edge after a tick, outputs wait a full period
        check_span("hold_a", 3, 4'b1000);
        left_sw = 1'b0;
        check_span("hold_b", 4, 4'b1000);
        cycles(1);
        chk("hold_tick", 4'b1001);
        period("hold_update", 3'b100, 3'b000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
